// File: rtl/id_ex_pipe.sv
// ID->EX pipeline register chain: DEPTH stages carrying the decoded ALU op and operands,
// with per-stage valid, flush-to-bubble, global stall hold and saturating event counters.
module id_ex_pipe #(
    parameter int DATA_W = 16,
    parameter int OP_W   = 3,
    parameter int SEL_W  = 3,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [OP_W-1:0]   id_aluop,
    input  logic [SEL_W-1:0]  id_alusel,
    input  logic [DATA_W-1:0] id_reg0,
    input  logic [DATA_W-1:0] id_reg1,
    input  logic [ADDR_W-1:0] id_waddr,
    input  logic              id_we,
    output logic              ex_valid,
    output logic [OP_W-1:0]   ex_aluop,
    output logic [SEL_W-1:0]  ex_alusel,
    output logic [DATA_W-1:0] ex_reg0,
    output logic [DATA_W-1:0] ex_reg1,
    output logic [ADDR_W-1:0] ex_waddr,
    output logic              ex_we,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    generate
        if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
            $error("id_ex_pipe: DEPTH must be in 1..4");
        end
    endgenerate

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic              valid_p [DEPTH];
    logic [OP_W-1:0]   aluop_p [DEPTH];
    logic [SEL_W-1:0]  alusel_p[DEPTH];
    logic [DATA_W-1:0] reg0_p  [DEPTH];
    logic [DATA_W-1:0] reg1_p  [DEPTH];
    logic [ADDR_W-1:0] waddr_p [DEPTH];
    logic              we_p    [DEPTH];

    // Stage 0: capture from decode; an invalid slot can never carry a write enable
    always_ff @(posedge clk or posedge rst) begin
        if (rst || flush) begin
            valid_p[0]  <= 1'b0;
            aluop_p[0]  <= '0;
            alusel_p[0] <= '0;
            reg0_p[0]   <= '0;
            reg1_p[0]   <= '0;
            waddr_p[0]  <= '0;
            we_p[0]     <= 1'b0;
        end else if (!stall) begin
            valid_p[0]  <= id_valid;
            aluop_p[0]  <= id_aluop;
            alusel_p[0] <= id_alusel;
            reg0_p[0]   <= id_reg0;
            reg1_p[0]   <= id_reg1;
            waddr_p[0]  <= id_waddr;
            we_p[0]     <= id_we & id_valid;
        end
    end

    // Stages 1..DEPTH-1: plain shift with the same flush/stall priority
    generate
        for (genvar k = 1; k < DEPTH; k++) begin : g_stage
            always_ff @(posedge clk or posedge rst) begin
                if (rst || flush) begin
                    valid_p[k]  <= 1'b0;
                    aluop_p[k]  <= '0;
                    alusel_p[k] <= '0;
                    reg0_p[k]   <= '0;
                    reg1_p[k]   <= '0;
                    waddr_p[k]  <= '0;
                    we_p[k]     <= 1'b0;
                end else if (!stall) begin
                    valid_p[k]  <= valid_p[k-1];
                    aluop_p[k]  <= aluop_p[k-1];
                    alusel_p[k] <= alusel_p[k-1];
                    reg0_p[k]   <= reg0_p[k-1];
                    reg1_p[k]   <= reg1_p[k-1];
                    waddr_p[k]  <= waddr_p[k-1];
                    we_p[k]     <= we_p[k-1];
                end
            end
        end
    endgenerate

    // Event counters: a flush cycle counts only as a flush even if stall is also high
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (flush) begin
            flush_cnt <= sat_inc(flush_cnt);
        end else if (stall) begin
            stall_cnt <= sat_inc(stall_cnt);
        end
    end

    // Execute side: driven straight from the last stage registers
    assign ex_valid  = valid_p[DEPTH-1];
    assign ex_aluop  = aluop_p[DEPTH-1];
    assign ex_alusel = alusel_p[DEPTH-1];
    assign ex_reg0   = reg0_p[DEPTH-1];
    assign ex_reg1   = reg1_p[DEPTH-1];
    assign ex_waddr  = waddr_p[DEPTH-1];
    assign ex_we     = we_p[DEPTH-1];

endmodule

// File: tb/tb_id_ex_pipe.sv
// Bench for id_ex_pipe: a DEPTH=1/CNT_W=2 instance and a DEPTH=2/CNT_W=16 instance share stimulus.
module tb_id_ex_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        id_valid = 1'b0;
    logic [2:0]  id_aluop = '0;
    logic [2:0]  id_alusel = '0;
    logic [15:0] id_reg0 = '0;
    logic [15:0] id_reg1 = '0;
    logic [3:0]  id_waddr = '0;
    logic        id_we = 1'b0;

    logic        a_valid, a_we, b_valid, b_we;
    logic [2:0]  a_aluop, a_alusel, b_aluop, b_alusel;
    logic [15:0] a_reg0, a_reg1, b_reg0, b_reg1;
    logic [3:0]  a_waddr, b_waddr;
    logic [1:0]  a_sc, a_fc;
    logic [15:0] b_sc, b_fc;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    id_ex_pipe #(.DEPTH(1), .CNT_W(2)) u_a (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .id_valid(id_valid), .id_aluop(id_aluop), .id_alusel(id_alusel),
        .id_reg0(id_reg0), .id_reg1(id_reg1), .id_waddr(id_waddr), .id_we(id_we),
        .ex_valid(a_valid), .ex_aluop(a_aluop), .ex_alusel(a_alusel),
        .ex_reg0(a_reg0), .ex_reg1(a_reg1), .ex_waddr(a_waddr), .ex_we(a_we),
        .stall_cnt(a_sc), .flush_cnt(a_fc)
    );

    id_ex_pipe #(.DEPTH(2), .CNT_W(16)) u_b (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .id_valid(id_valid), .id_aluop(id_aluop), .id_alusel(id_alusel),
        .id_reg0(id_reg0), .id_reg1(id_reg1), .id_waddr(id_waddr), .id_we(id_we),
        .ex_valid(b_valid), .ex_aluop(b_aluop), .ex_alusel(b_alusel),
        .ex_reg0(b_reg0), .ex_reg1(b_reg1), .ex_waddr(b_waddr), .ex_we(b_we),
        .stall_cnt(b_sc), .flush_cnt(b_fc)
    );

    function automatic logic [43:0] mk(input logic v, input logic [2:0] op, input logic [2:0] sel,
                                       input logic [15:0] r0, input logic [15:0] r1,
                                       input logic [3:0] wa, input logic we);
        return {v, op, sel, r0, r1, wa, we};
    endfunction

    wire [43:0] a_bus = {a_valid, a_aluop, a_alusel, a_reg0, a_reg1, a_waddr, a_we};
    wire [43:0] b_bus = {b_valid, b_aluop, b_alusel, b_reg0, b_reg1, b_waddr, b_we};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic s, input logic f, input logic [43:0] bus);
        stall = s;
        flush = f;
        {id_valid, id_aluop, id_alusel, id_reg0, id_reg1, id_waddr, id_we} = bus;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        stall;
        logic        flush;
        logic [43:0] in_bus;
        logic [43:0] exp_bus;
        int          exp_sc;
        int          exp_fc;
    } vec_t;

    vec_t tbl[11];

    logic [43:0] ea, eb, ec, ed, ee, ef, eg, ed_out, ec_out;

    initial begin
        ea = mk(1'b1, 3'd1, 3'd2, 16'h1111, 16'h2222, 4'd3, 1'b1);
        eb = mk(1'b1, 3'd2, 3'd3, 16'h8000, 16'hFFFF, 4'd15, 1'b1);
        ec = mk(1'b1, 3'd7, 3'd7, 16'h7FFF, 16'h0001, 4'd9, 1'b0);
        ed = mk(1'b0, 3'd4, 3'd5, 16'h1234, 16'h5678, 4'd5, 1'b1);
        ee = mk(1'b1, 3'd3, 3'd1, 16'hAAAA, 16'h5555, 4'd2, 1'b1);
        ef = mk(1'b1, 3'd5, 3'd6, 16'h0F0F, 16'hF0F0, 4'd12, 1'b1);
        eg = mk(1'b1, 3'd6, 3'd4, 16'hBEEF, 16'hCAFE, 4'd7, 1'b1);
        ed_out = mk(1'b0, 3'd4, 3'd5, 16'h1234, 16'h5678, 4'd5, 1'b0);
        ec_out = ec;

        // Expected values are for the DEPTH=2 instance, starting from a cleared pipe.
        tbl[0]  = '{1'b0, 1'b0, ea,    44'd0,  0, 0};
        tbl[1]  = '{1'b0, 1'b0, eb,    ea,     0, 0};
        tbl[2]  = '{1'b1, 1'b0, ec,    ea,     1, 0};
        tbl[3]  = '{1'b1, 1'b0, ec,    ea,     2, 0};
        tbl[4]  = '{1'b0, 1'b0, ec,    eb,     2, 0};
        tbl[5]  = '{1'b0, 1'b0, ed,    ec_out, 2, 0};
        tbl[6]  = '{1'b0, 1'b0, ee,    ed_out, 2, 0};
        tbl[7]  = '{1'b1, 1'b1, ef,    44'd0,  2, 1};
        tbl[8]  = '{1'b0, 1'b0, ef,    44'd0,  2, 1};
        tbl[9]  = '{1'b0, 1'b1, eg,    44'd0,  2, 2};
        tbl[10] = '{1'b0, 1'b0, 44'd0, 44'd0,  2, 2};

        // Reset state, before any clock edge
        #1 rst = 1'b1;
        #2;
        check("rst_a_bus", 64'(a_bus), 64'd0);
        check("rst_b_bus", 64'(b_bus), 64'd0);
        check("rst_cnts", {a_sc, a_fc, b_sc, b_fc}, 64'd0);
        step();
        check("rst_held_b_bus", 64'(b_bus), 64'd0);
        rst = 1'b0;

        // Single-stage latency and two-stage latency on the same entry
        drive(1'b0, 1'b0, ea);
        step();
        check("d1_latency_a", 64'(a_bus), 64'(ea));
        check("d2_not_yet_b", 64'(b_bus), 64'd0);

        // Asynchronous clear of a partially filled pipe
        rst = 1'b1;
        #1;
        check("async_rst_a", 64'(a_bus), 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].stall, tbl[i].flush, tbl[i].in_bus);
            step();
            check($sformatf("vec%0d_ex", i), 64'(b_bus), 64'(tbl[i].exp_bus));
            check($sformatf("vec%0d_cnt", i), {b_sc, b_fc}, {32'd0, 16'(tbl[i].exp_sc), 16'(tbl[i].exp_fc)});
        end

        // Counter saturation: 2-bit counters stick at 3, 16-bit ones keep counting
        rst = 1'b1;
        #1 rst = 1'b0;
        drive(1'b1, 1'b0, ea);
        for (int i = 0; i < 6; i++) step();
        check("sat_stall_a", 64'(a_sc), 64'd3);
        check("stall_b", 64'(b_sc), 64'd6);
        drive(1'b0, 1'b1, ea);
        for (int i = 0; i < 4; i++) step();
        check("sat_flush_a", 64'(a_fc), 64'd3);
        check("flush_b", 64'(b_fc), 64'd4);
        check("stall_a_kept", 64'(a_sc), 64'd3);

        // Refill, then reset between edges with live data and nonzero counters
        drive(1'b0, 1'b0, ea);
        step();
        drive(1'b0, 1'b0, eb);
        step();
        check("refill_a", 64'(a_bus), 64'(eb));
        check("refill_b", 64'(b_bus), 64'(ea));
        #2 rst = 1'b1;
        #1;
        check("midcyc_rst_a", 64'(a_bus), 64'd0);
        check("midcyc_rst_b", 64'(b_bus), 64'd0);
        check("midcyc_rst_cnt", {a_sc, a_fc, b_sc, b_fc}, 64'd0);
        step();
        check("rst_hold_b", 64'(b_bus), 64'd0);
        rst = 1'b0;
        drive(1'b0, 1'b0, 44'd0);
        step();
        check("post_rst_b", 64'(b_bus), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
